// File: rtl/smb_pkg.sv
// Shared types and helpers for the stream memory bridge.
package smb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_RD_RESP = 3'd2,
        ST_WR_WAIT = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_ACK_RD  = 3'd5,
        ST_ACK_WR  = 3'd6
    } state_e;

    typedef enum logic {
        GNT_READ  = 1'b0,
        GNT_WRITE = 1'b1
    } grant_e;

    localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;

    // Out of range: below base, past the last word, or not word aligned.
    function automatic logic addr_bad(input logic [63:0] addr,
                                      input logic [63:0] base,
                                      input int unsigned aw);
        logic [63:0] off;
        off = addr - base;
        return (addr < base) || ((off >> (aw + 2)) != 64'd0) || (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/smb_sp_ram.sv
// Single-port DEPTH x 32 backing store: synchronous write, registered read.
module smb_sp_ram #(
    parameter int unsigned DEPTH = 65536,
    parameter int unsigned AW    = 16
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    // One access per cycle; a write does not update the read register.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/stream_mem_bridge.sv
// Memory-side responder for the scratchpad stream port: one word per request,
// programmable read/write latency, round-robin read/write arbitration.
// Optional statistics counters: define STREAM_MEM_BRIDGE_STATS_EN.
module stream_mem_bridge
    import smb_pkg::*;
#(
    parameter int unsigned DEPTH  = 65536,
    parameter int unsigned AW     = 16,
    parameter int unsigned RD_LAT = 4,
    parameter int unsigned WR_LAT = 2,
    parameter logic [63:0] BASE   = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read_enable,
    input  logic [63:0] read_addr,
    input  logic        finish_read,
    output logic [63:0] read_ready,
    output logic [31:0] read_data,
    input  logic        write_enable,
    input  logic [63:0] write_addr,
    input  logic [31:0] write_data,
    input  logic        finish_write,
    output logic [63:0] write_ready,
    output logic        addr_err,
    output logic        busy
`ifdef STREAM_MEM_BRIDGE_STATS_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count,
    output logic [31:0] stall_cycles
`endif
);

    localparam int unsigned CNT_W = 8;

    state_e           state_q, state_d;
    grant_e           last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             err_q, err_d;
    logic             addr_err_q, addr_err_d;
    logic             rd_rdy_q, rd_rdy_d;
    logic             wr_rdy_q, wr_rdy_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             busy_q, busy_d;

    logic             take_rd_c, take_wr_c;
    logic             ram_en_c, ram_we_c;
    logic [31:0]      ram_rdata;
    logic [63:0]      rd_off_c, wr_off_c;

    assign rd_off_c = read_addr - BASE;
    assign wr_off_c = write_addr - BASE;

    // Grant decision in IDLE; simultaneous requests alternate.
    always_comb begin
        take_rd_c = 1'b0;
        take_wr_c = 1'b0;
        if (state_q == ST_IDLE) begin
            if (read_enable && write_enable) begin
                take_rd_c = (last_grant_q == GNT_WRITE);
                take_wr_c = (last_grant_q == GNT_READ);
            end else begin
                take_rd_c = read_enable;
                take_wr_c = write_enable;
            end
        end
    end

    // Next-state, latched request, RAM control and response strobes.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        addr_err_d   = addr_err_q;
        rd_rdy_d     = 1'b0;
        wr_rdy_d     = 1'b0;
        rdata_d      = rdata_q;
        ram_en_c     = 1'b0;
        ram_we_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (take_rd_c) begin
                    state_d      = ST_RD_WAIT;
                    last_grant_d = GNT_READ;
                    idx_d        = AW'(rd_off_c >> 2);
                    err_d        = addr_bad(read_addr, BASE, AW);
                    addr_err_d   = addr_err_q | addr_bad(read_addr, BASE, AW);
                end else if (take_wr_c) begin
                    state_d      = ST_WR_WAIT;
                    last_grant_d = GNT_WRITE;
                    idx_d        = AW'(wr_off_c >> 2);
                    wdata_d      = write_data;
                    err_d        = addr_bad(write_addr, BASE, AW);
                    addr_err_d   = addr_err_q | addr_bad(write_addr, BASE, AW);
                end
            end
            ST_RD_WAIT: begin
                if (cnt_q == CNT_W'(RD_LAT - 1)) begin
                    ram_en_c = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_RD_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RD_RESP: begin
                rd_rdy_d = 1'b1;
                rdata_d  = err_q ? ERR_WORD : ram_rdata;
                state_d  = ST_ACK_RD;
            end
            ST_WR_WAIT: begin
                if ((cnt_q == '0) && !err_q) begin
                    ram_en_c = 1'b1;
                    ram_we_c = 1'b1;
                end
                if (cnt_q == CNT_W'(WR_LAT - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_WR_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WR_RESP: begin
                wr_rdy_d = 1'b1;
                state_d  = ST_ACK_WR;
            end
            ST_ACK_RD: begin
                if (finish_read || !read_enable) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK_WR: begin
                if (finish_write || !write_enable) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GNT_WRITE;
            cnt_q        <= '0;
            idx_q        <= '0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            addr_err_q   <= 1'b0;
            rd_rdy_q     <= 1'b0;
            wr_rdy_q     <= 1'b0;
            rdata_q      <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            addr_err_q   <= addr_err_d;
            rd_rdy_q     <= rd_rdy_d;
            wr_rdy_q     <= wr_rdy_d;
            rdata_q      <= rdata_d;
            busy_q       <= busy_d;
        end
    end

    smb_sp_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en_c),
        .we    (ram_we_c),
        .addr  (idx_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    assign read_ready  = 64'(rd_rdy_q);
    assign write_ready = 64'(wr_rdy_q);
    assign read_data   = rdata_q;
    assign addr_err    = addr_err_q;
    assign busy        = busy_q;

`ifdef STREAM_MEM_BRIDGE_STATS_EN
    logic [31:0] rd_count_q, rd_count_d;
    logic [31:0] wr_count_q, wr_count_d;
    logic [31:0] stall_q, stall_d;
    logic        rd_side_c, stall_c;

    // Saturating response and stall counters.
    always_comb begin
        rd_side_c  = (state_q == ST_RD_WAIT) || (state_q == ST_RD_RESP) || (state_q == ST_ACK_RD);
        stall_c    = (state_q == ST_IDLE) ? (read_enable && write_enable)
                   : ((rd_side_c && write_enable) || (!rd_side_c && read_enable));
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        stall_d    = stall_q;
        if ((state_q == ST_RD_RESP) && (rd_count_q != 32'hFFFF_FFFF)) begin
            rd_count_d = rd_count_q + 32'd1;
        end
        if ((state_q == ST_WR_RESP) && (wr_count_q != 32'hFFFF_FFFF)) begin
            wr_count_d = wr_count_q + 32'd1;
        end
        if (stall_c && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
            stall_q    <= '0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
            stall_q    <= stall_d;
        end
    end

    assign rd_count     = rd_count_q;
    assign wr_count     = wr_count_q;
    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_stream_mem_bridge.sv
// Directed bench for stream_mem_bridge: latency, data, handshake, arbitration,
// out-of-range handling and reset in mid-transaction.
module tb_stream_mem_bridge;

    localparam int unsigned DEPTH  = 65536;
    localparam int unsigned RD_LAT = 4;
    localparam int unsigned WR_LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        read_enable = 1'b0;
    logic [63:0] read_addr = '0;
    logic        finish_read = 1'b0;
    logic [63:0] read_ready;
    logic [31:0] read_data;
    logic        write_enable = 1'b0;
    logic [63:0] write_addr = '0;
    logic [31:0] write_data = '0;
    logic        finish_write = 1'b0;
    logic [63:0] write_ready;
    logic        addr_err;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;
    int rd_pulses = 0;

    stream_mem_bridge #(
        .DEPTH  (DEPTH),
        .AW     (16),
        .RD_LAT (RD_LAT),
        .WR_LAT (WR_LAT),
        .BASE   (64'd0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .read_enable  (read_enable),
        .read_addr    (read_addr),
        .finish_read  (finish_read),
        .read_ready   (read_ready),
        .read_data    (read_data),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .finish_write (finish_write),
        .write_ready  (write_ready),
        .addr_err     (addr_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (read_ready === 64'd1) rd_pulses++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [31:0] data);
        int n;
        n = 0;
        write_enable = 1'b1;
        write_addr   = addr;
        write_data   = data;
        @(posedge clk); #1;
        write_addr = 64'hFFFF_0000;
        write_data = 32'h0;
        while (n < 40 && write_ready !== 64'd1) begin
            @(posedge clk); #1;
            n++;
        end
        check("wr_latency", 64'(n), 64'(WR_LAT + 1));
        finish_write = 1'b1;
        write_enable = 1'b0;
        @(posedge clk); #1;
        finish_write = 1'b0;
        check("wr_pulse_width", write_ready, 64'd0);
    endtask

    task automatic do_read(input logic [63:0] addr, input bit keep_en, input bit drop_en,
                           input logic [63:0] next_addr, output logic [31:0] data);
        int n;
        n = 0;
        read_enable = 1'b1;
        read_addr   = addr;
        @(posedge clk); #1;
        read_addr = 64'hFFFF_0000;
        if (drop_en) read_enable = 1'b0;
        while (n < 40 && read_ready !== 64'd1) begin
            @(posedge clk); #1;
            n++;
        end
        check("rd_latency", 64'(n), 64'(RD_LAT + 1));
        data        = read_data;
        finish_read = 1'b1;
        if (keep_en) read_addr = next_addr;
        else read_enable = 1'b0;
        @(posedge clk); #1;
        finish_read = 1'b0;
        check("rd_pulse_width", read_ready, 64'd0);
    endtask

    task automatic serve_both(input logic [63:0] raddr, input logic [63:0] waddr,
                              input logic [31:0] wdata, output bit wr_first,
                              output logic [31:0] rdata);
        bit rd_done, wr_done;
        rd_done  = 1'b0;
        wr_done  = 1'b0;
        wr_first = 1'b0;
        rdata    = '0;
        read_enable  = 1'b1;
        read_addr    = raddr;
        write_enable = 1'b1;
        write_addr   = waddr;
        write_data   = wdata;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            finish_read  = 1'b0;
            finish_write = 1'b0;
            if (rd_done && wr_done) break;
            if (write_ready === 64'd1) begin
                wr_first     = !rd_done;
                wr_done      = 1'b1;
                finish_write = 1'b1;
                write_enable = 1'b0;
            end
            if (read_ready === 64'd1) begin
                rdata       = read_data;
                rd_done     = 1'b1;
                finish_read = 1'b1;
                read_enable = 1'b0;
            end
        end
        read_enable  = 1'b0;
        write_enable = 1'b0;
        check("both_served", 64'({rd_done, wr_done}), 64'd3);
    endtask

    initial begin
        logic [31:0] d;
        bit          wf;
        int          p0;

        // Reset state
        #1;
        check("rst_read_ready", read_ready, 64'd0);
        check("rst_write_ready", write_ready, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_addr_err", 64'(addr_err), 64'd0);
        check("rst_read_data", 64'(read_data), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Basic write then read of word 5
        do_write(64'd20, 32'h0000_1234);
        do_read(64'd20, 1'b0, 1'b0, 64'd0, d);
        check("rd_word5", 64'(d), 64'h1234);
        check("read_data_hold", 64'(read_data), 64'h1234);

        // Write/read-back, read request dropped during the wait
        do_write(64'd8, 32'h0000_CAFE);
        do_read(64'd8, 1'b0, 1'b1, 64'd0, d);
        check("rd_cafe_dropped_en", 64'(d), 64'hCAFE);

        // Streaming reads with read_enable held high
        for (int i = 0; i < 16; i++) begin
            do_write(64'h100 + 64'(4 * i), 32'h1000 + 32'(i));
        end
        p0 = rd_pulses;
        for (int i = 0; i < 16; i++) begin
            do_read(64'h100 + 64'(4 * i), (i != 15), 1'b0, 64'h100 + 64'(4 * (i + 1)), d);
            check("stream_data", 64'(d), 64'h1000 + 64'(i));
        end
        check("stream_pulse_count", 64'(rd_pulses - p0), 64'd16);

        // Arbitration: last grant was a read, so the write wins first
        serve_both(64'd160, 64'd160, 32'hBEEF_0001, wf, d);
        check("rr1_write_first", 64'(wf), 64'd1);
        check("rr1_read_sees_write", 64'(d), 64'hBEEF_0001);

        // Last grant now a write (after a lone write), so the read wins first
        do_write(64'd164, 32'h1111_2222);
        serve_both(64'd164, 64'd164, 32'h3333_4444, wf, d);
        check("rr2_read_first", 64'(wf), 64'd0);
        check("rr2_read_old", 64'(d), 64'h1111_2222);
        do_read(64'd164, 1'b0, 1'b0, 64'd0, d);
        check("rr2_write_landed", 64'(d), 64'h3333_4444);
        check("no_err_yet", 64'(addr_err), 64'd0);

        // Out-of-range read and misaligned write
        do_write(64'd0, 32'hA5A5_A5A5);
        do_read(64'(4 * DEPTH), 1'b0, 1'b0, 64'd0, d);
        check("oor_read_word", 64'(d), 64'hDEAD_BEEF);
        check("oor_addr_err", 64'(addr_err), 64'd1);
        do_write(64'd2, 32'h5555_5555);
        do_read(64'd0, 1'b0, 1'b0, 64'd0, d);
        check("oor_write_dropped", 64'(d), 64'hA5A5_A5A5);
        check("addr_err_sticky", 64'(addr_err), 64'd1);

        // Reset while a read is waiting
        read_enable = 1'b1;
        read_addr   = 64'd20;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("busy_in_wait", 64'(busy), 64'd1);
        p0 = rd_pulses;
        reset       = 1'b1;
        read_enable = 1'b0;
        #1;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_ready", read_ready, 64'd0);
        check("rst_mid_addr_err", 64'(addr_err), 64'd0);
        repeat (6) @(posedge clk);
        #1;
        check("rst_no_late_pulse", 64'(rd_pulses - p0), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_idle", 64'(busy), 64'd0);
        do_read(64'd20, 1'b0, 1'b0, 64'd0, d);
        check("post_rst_read", 64'(d), 64'h1234);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
